rr_mux_scheduler: RTL

//  Round-robin scheduler that shares one 8:1 select path between 8 requesters.

---
 rtl/rr_mux_scheduler_pkg.sv | 14 +
 rtl/rr_pick8.sv | 25 ++
 rtl/rr_mux_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/rr_mux_scheduler_pkg.sv
// Shared encodings for the round-robin 8:1 mux scheduler (optional feature: MUX_SCHED_TIMEOUT_EN).
// Holds the FSM state encoding and requester/select widths.
package rr_mux_scheduler_pkg;

   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping 7 -> 0.
// Zero latency; valid_o low when no request is set (idx_o then 0).
module rr_pick8
   import rr_mux_scheduler_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic               valid_o,
   output logic [SEL_W-1:0]   idx_o
);

   logic [SEL_W-1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      cand    = '0;
      idx_o   = '0;
      valid_o = |req_i;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr_i + SEL_W'(k);
         if (req_i[cand]) idx_o = cand;
      end
   end

endmodule

// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler sharing one 8:1 select path; O registers D of the granted line, one cycle late.
// Grant held until REQ drops (or hold limit with MUX_SCHED_TIMEOUT_EN), then one GAP cycle before re-arbitration.
module rr_mux_scheduler
   import rr_mux_scheduler_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int HOLD_W      = 3
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] d_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               s0_o,
   output logic               s1_o,
   output logic               s2_o,
   output logic               o_o,
   output logic               busy_o
);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** HOLD_W)) begin : g_bad_hold
      $error("rr_mux_scheduler: HOLD_CYCLES out of range for HOLD_W");
   end

   state_e           st_q, st_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             o_q, o_d;
   logic             pick_vld;
   logic [SEL_W-1:0] pick_idx;
   logic             hold_done;
   logic             grant_end;

   rr_pick8 u_pick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .valid_o (pick_vld),
      .idx_o   (pick_idx)
   );

`ifdef MUX_SCHED_TIMEOUT_EN
   localparam logic [HOLD_W-1:0] CNT_MAX = HOLD_W'(HOLD_CYCLES - 1);

   logic [HOLD_W-1:0] cnt_q, cnt_d;

   assign hold_done = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q;
      if (st_q != ST_GRANT)  cnt_d = '0;
      else if (!hold_done)   cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   assign hold_done = 1'b0;
`endif

   assign grant_end = !req_i[sel_q] || hold_done;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st_q  <= ST_IDLE;
         sel_q <= '0;
         ptr_q <= '0;
         o_q   <= 1'b0;
      end else begin
         st_q  <= st_d;
         sel_q <= sel_d;
         ptr_q <= ptr_d;
         o_q   <= o_d;
      end
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE:  if (pick_vld)  st_d = ST_GRANT;
         ST_GRANT: if (grant_end) st_d = ST_GAP;
         ST_GAP:                  st_d = ST_IDLE;
         default:                 st_d = ST_IDLE;
      endcase
   end

   // Select and O hold through GAP/IDLE so the last sampled bit stays visible after exit.
   always_comb begin
      sel_d = sel_q;
      ptr_d = ptr_q;
      o_d   = o_q;
      if (st_q == ST_IDLE && pick_vld) sel_d = pick_idx;
      if (st_q == ST_GRANT) begin
         o_d = d_i[sel_q];
         if (grant_end) ptr_d = sel_q + 1'b1;
      end
   end

   always_comb begin
      busy_o = (st_q == ST_GRANT);
      gnt_o  = busy_o ? (NUM_REQ'(1) << sel_q) : '0;
      {s0_o, s1_o, s2_o} = sel_q;
      o_o    = o_q;
   end

endmodule
